esm_issuer: RTL and testbench
=============================

ESM_ISSUER -- requirements
Module: esm_issuer

Interface
REQ-001 SHALL have parameter Instruction_word_size, default 16, the instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, the program memory depth; power of two, at least 2; AW = log2(DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_en  input  1  program-memory write strobe.
REQ-006 SHALL have port load_addr  input  AW  program-memory write address.
REQ-007 SHALL have port load_data  input  Instruction_word_size  program-memory write data.
REQ-008 SHALL have port start  input  1  begin-issue request.
REQ-009 SHALL have port length  input  AW+1  number of instructions to issue.
REQ-010 SHALL have port loop  input  1  repeat the program continuously when high.
REQ-011 SHALL have port abort  input  1  stop issuing.
REQ-012 SHALL have port Instr_out  output  Instruction_word_size  issued instruction; registered.
REQ-013 SHALL have port instr_valid  output  1  Instr_out holds a valid instruction.
REQ-014 SHALL have port instr_ready  input  1  the downstream ESM accepts the instruction.
REQ-015 SHALL have port busy  output  1  high while in state ISSUE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port issued_cnt  output  16  count of completed transfers.

Function
REQ-018 SHALL implement states IDLE, ISSUE and DONE; busy = (state == ISSUE).
REQ-019 SHALL write load_data to mem[load_addr] on load_en only in IDLE or DONE; load_en SHALL be ignored in ISSUE.
REQ-020 SHALL, on start in IDLE or DONE with length != 0, capture len = min(length, DEPTH) and loop, set pc = 0, clear issued_cnt, enter ISSUE, and drive instr_valid = 1 with Instr_out = mem[0] on the next cycle.
REQ-021 SHALL, on start with length == 0, issue nothing, pulse done one cycle later and go to DONE.
REQ-022 SHALL count a transfer when instr_valid && instr_ready at a rising edge.
REQ-023 SHALL hold Instr_out and instr_valid stable while instr_valid && !instr_ready.
REQ-024 SHALL, after a transfer at pc < len-1, present mem[pc+1] on the next cycle with no bubble (one instruction per cycle when ready is held high).
REQ-025 SHALL, after a transfer at pc == len-1: with loop captured high, wrap pc to 0 and continue; with loop low, deassert instr_valid, pulse done for one cycle and enter DONE.
REQ-026 SHALL ignore start while in ISSUE.
REQ-027 SHALL, on abort in ISSUE, go to IDLE next cycle with instr_valid = 0 and no done pulse; a transfer completing in the same cycle as abort SHALL still be counted.
REQ-028 SHALL increment issued_cnt by 1 per transfer, saturating at 16'hFFFF.
REQ-029 SHALL leave Instr_out at its last value whenever instr_valid is low.

Reset
REQ-030 SHALL, while rst is low and regardless of state (including mid-ISSUE), force state = IDLE, pc = 0, Instr_out = 0, instr_valid = 0, busy = 0, done = 0, and issued_cnt = 0.
REQ-031 SHALL leave program memory contents unchanged by reset.

Structure
REQ-032 SHALL take the state enum and the default widths (16 and 16) from shared package esm_pkg.
REQ-033 SHALL place the program memory in sub-module esm_prog_mem: synchronous write, combinational read.

Verification
REQ-034 SHALL cover: load mem[0..4] = 16'h0000..16'h0004, start with length = 5, instr_ready = 1 -> 16'h0000..16'h0004 issued on 5 consecutive cycles, done pulse, issued_cnt = 5.
REQ-035 SHALL cover: the same program with instr_ready low for 3 cycles while 16'h0002 is presented -> 16'h0002 held stable, no duplicate or skipped instruction, issued_cnt = 5.
REQ-036 SHALL cover: length = 3, loop = 1, 7 transfers, then abort -> sequence 0,1,2,0,1,2,0, then IDLE, no done pulse, issued_cnt = 7.
REQ-037 SHALL cover: length = 0 -> done pulse, instr_valid never asserted; length = 20 with DEPTH = 16 -> exactly 16 instructions issued.
REQ-038 SHALL cover: rst driven low mid-ISSUE at the third instruction -> outputs reset immediately (asynchronously); a new start then reissues from mem[0] with memory intact.
REQ-039 SHALL cover: load_en in ISSUE to address 1 with data 16'hBEEF -> memory unchanged and 16'h0001 is still issued.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared types and default sizes for the ESM instruction issuer.
package esm_pkg;
  localparam int INSTR_W    = 16;
  localparam int PROG_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/esm_prog_mem.sv
// Program memory: synchronous write, combinational read, never reset.
module esm_prog_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/esm_issuer.sv
// Issues a loaded program one instruction per accepted transfer, optionally looping.
// Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
// while instr_valid is high and instr_ready low, Instr_out and instr_valid hold.
module esm_issuer import esm_pkg::*; #(
  parameter int Instruction_word_size = INSTR_W,
  parameter int DEPTH                 = PROG_DEPTH,
  localparam int AW                   = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_en,
  input  logic [AW-1:0]                    load_addr,
  input  logic [Instruction_word_size-1:0] load_data,
  input  logic                             start,
  input  logic [AW:0]                      length,
  input  logic                             loop,
  input  logic                             abort,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      issued_cnt,
  output logic [1:0]                       dbg_state
);
  localparam logic [AW:0] DepthL = (AW+1)'(DEPTH);

  state_e                           state_q, state_d;
  logic [AW-1:0]                    pc_q, pc_d;
  logic [AW:0]                      len_q, len_d;
  logic                             loop_q, loop_d;
  logic [Instruction_word_size-1:0] instr_q, instr_d;
  logic                             valid_q, valid_d;
  logic                             done_q, done_d;
  logic [15:0]                      cnt_q, cnt_d;

  logic                             xfer, last, mem_we;
  logic [AW:0]                      len_cap;
  logic [AW-1:0]                    rd_addr;
  logic [Instruction_word_size-1:0] rd_data;

  assign xfer    = valid_q && instr_ready;
  assign last    = ({1'b0, pc_q} == (len_q - 1'b1));
  assign mem_we  = load_en && (state_q != ISSUE);
  assign len_cap = (length > DepthL) ? DepthL : length;
  // Look-ahead address: the word presented after the current transfer.
  assign rd_addr = (state_q == ISSUE && !last) ? pc_q + 1'b1 : '0;

  esm_prog_mem #(.W(Instruction_word_size), .DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    loop_d  = loop_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (xfer && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d = '0;
          pc_d  = '0;
          if (length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            len_d   = len_cap;
            loop_d  = loop;
            state_d = ISSUE;
            valid_d = 1'b1;
            instr_d = rd_data;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (!last) begin
            pc_d    = pc_q + 1'b1;
            instr_d = rd_data;
          end else if (loop_q) begin
            pc_d    = '0;
            instr_d = rd_data;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == ISSUE);
  assign done        = done_q;
  assign issued_cnt  = cnt_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_esm_issuer.sv
// Randomized and directed bench for esm_issuer with a queue-based scoreboard.
module tb_esm_issuer;
  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic          loop = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  Instr_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          busy, done;
  logic [15:0]   issued_cnt;
  logic [1:0]    dbg_state;

  esm_issuer #(.Instruction_word_size(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .length(length), .loop(loop),
    .abort(abort), .Instr_out(Instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done),
    .issued_cnt(issued_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_model [DEPTH];
  int done_cnt = 0;
  int valid_cycles = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples mid-cycle; valid && ready here means a transfer at the next edge.
  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_rst = 1'b0;
  logic [W-1:0] prev_instr = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_rst && prev_valid && !prev_ready && !prev_abort) begin
        check("hold_valid", instr_valid, 1);
        check("hold_data", Instr_out, prev_instr);
      end
      if (instr_valid) valid_cycles++;
      if (done) done_cnt++;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_xfer: got %0h expected none at %0t", Instr_out, $time);
        end else begin
          check("xfer_data", Instr_out, exp_q.pop_front());
        end
      end
    end
    prev_valid = instr_valid;
    prev_ready = instr_ready;
    prev_abort = abort;
    prev_rst   = rst;
    prev_instr = Instr_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [W-1:0] data);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    tick();
    load_en = 1'b0;
    mem_model[addr] = data;
  endtask

  // Reference: a run issues mem[i % eff] for each transfer, eff = min(length, DEPTH).
  task automatic run_prog(input int len_i, input bit loop_i, input int abort_after,
                          input int stall_pct, input bit load_hook);
    int eff, n_exp, tx, budget, d0, v0, stalls;
    bit aborted, finished, aborting;
    eff = (len_i > DEPTH) ? DEPTH : len_i;
    if (loop_i) aborted = (eff > 0);
    else        aborted = (abort_after > 0 && abort_after <= eff);
    n_exp = aborted ? abort_after : eff;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(mem_model[i % eff]);
    d0 = done_cnt;
    v0 = valid_cycles;
    tx = 0; budget = 0; stalls = 0;
    finished = 0; aborting = 0;
    start  = 1'b1;
    length = (AW+1)'(len_i);
    loop   = loop_i;
    tick();
    start = 1'b0;
    while (!finished && budget < 400) begin
      if (done) begin
        finished = 1;
      end else begin
        if (stall_pct < 0) begin
          if (instr_valid && Instr_out == 16'h0002 && stalls < 3) begin
            instr_ready = 1'b0;
            stalls++;
          end else instr_ready = 1'b1;
        end else begin
          instr_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        if (load_hook && budget == 0) begin
          load_en   = 1'b1;
          load_addr = AW'(1);
          load_data = 16'hBEEF;
        end
        if (instr_valid && instr_ready) begin
          tx++;
          if (abort_after > 0 && tx == abort_after) begin
            abort    = 1'b1;
            aborting = 1;
          end
        end
        tick();
        load_en = 1'b0;
        if (aborting) begin
          abort    = 1'b0;
          finished = 1;
        end
        budget++;
      end
    end
    if (!finished) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: got no end after %0d cycles expected done or abort", budget);
    end
    instr_ready = 1'b0;
    tick();
    check("issued_cnt", issued_cnt, n_exp);
    check("done_pulses", done_cnt - d0, aborted ? 0 : 1);
    check("done_width", done, 0);
    check("end_busy", busy, 0);
    check("end_valid", instr_valid, 0);
    check("queue_empty", exp_q.size(), 0);
    if (eff == 0) check("no_valid", valid_cycles - v0, 0);
    if (stall_pct < 0) check("stall_cycles", stalls, 3);
    exp_q.delete();
  endtask

  initial begin
    int rlen, rab, rstall;
    bit rloop;
    #2;
    check("rst_instr", Instr_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", issued_cnt, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) load_word(i, (i < 5) ? W'(i) : W'($urandom));

    run_prog(5, 0, 0, 0, 0);            // straight run, ready always high
    run_prog(5, 0, 0, -1, 0);           // 3-cycle stall on 16'h0002
    run_prog(3, 1, 7, 0, 0);            // loop then abort on 7th transfer
    run_prog(0, 0, 0, 0, 0);            // empty program
    run_prog(20, 0, 0, 0, 0);           // length clipped to DEPTH
    run_prog(5, 0, 0, 0, 1);            // write attempt during ISSUE is ignored

    // Asynchronous reset while the third instruction is presented.
    exp_q.push_back(mem_model[0]);
    exp_q.push_back(mem_model[1]);
    start = 1'b1; length = 5; loop = 1'b0;
    tick();
    start = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !(instr_valid && Instr_out == 16'h0002); i++) tick();
    rst = 1'b0;
    #1;
    check("arst_instr", Instr_out, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", issued_cnt, 0);
    check("arst_done", done, 0);
    check("arst_queue", exp_q.size(), 0);
    instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    run_prog(5, 0, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 3; k++) load_word($urandom_range(0, DEPTH-1), W'($urandom));
      rlen   = $urandom_range(0, 20);
      rloop  = 1'($urandom_range(0, 1));
      rstall = $urandom_range(0, 40);
      if (rloop) rab = $urandom_range(1, 25);
      else       rab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      run_prog(rlen, rloop, rab, rstall, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
